// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue
//   Circular instruction queue that sits between fetch and dispatch. Fetch
//   pushes {instr, PC, nPC} at the tail. Dispatch sees the head entry
//   combinationally and pops it when dispatch_ready is high. A pipeline
//   redirect (from_pipeline_take_resolved) empties the queue on the next
//   edge. Stored entry contents are left untouched by a redirect.
//
// Parameters
//   IQ_DEPTH      number of entries (power of two, >= 2)
//   LOG_IQ_DEPTH  log2(IQ_DEPTH)
//
// Ports
//   CLK                          clock, all state updates on the rising edge
//   nRST                         asynchronous active-low reset
//   from_fetch_ivalid            fetch presents an instruction this cycle
//   from_fetch_instr/PC/nPC      fetched instruction, its PC, predicted next PC
//   from_pipeline_take_resolved  redirect: flush the whole queue
//   dispatch_ready               dispatch consumes the head entry this cycle
//   to_dispatch_valid            head entry is valid
//   to_dispatch_instr/PC/nPC     fields of the head entry
//   iq_full                      queue holds IQ_DEPTH entries (fetch stall)
//   iq_count                     current occupancy
// ---------------------------------------------------------------------------
module instr_queue #(
  parameter int IQ_DEPTH     = 4,
  parameter int LOG_IQ_DEPTH = 2
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    from_fetch_ivalid,
  input  logic [31:0]             from_fetch_instr,
  input  logic [13:0]             from_fetch_PC,
  input  logic [13:0]             from_fetch_nPC,
  input  logic                    from_pipeline_take_resolved,
  input  logic                    dispatch_ready,
  output logic                    to_dispatch_valid,
  output logic [31:0]             to_dispatch_instr,
  output logic [13:0]             to_dispatch_PC,
  output logic [13:0]             to_dispatch_nPC,
  output logic                    iq_full,
  output logic [LOG_IQ_DEPTH:0]   iq_count
);

  typedef logic [31:0] word_t;
  typedef logic [13:0] pc_t;

  localparam logic [LOG_IQ_DEPTH-1:0] PTR_ONE  = LOG_IQ_DEPTH'(1);
  localparam logic [LOG_IQ_DEPTH:0]   CNT_ONE  = (LOG_IQ_DEPTH + 1)'(1);
  localparam logic [LOG_IQ_DEPTH:0]   CNT_FULL = (LOG_IQ_DEPTH + 1)'(IQ_DEPTH);

  word_t                   instr_mem [IQ_DEPTH];
  pc_t                     pc_mem    [IQ_DEPTH];
  pc_t                     npc_mem   [IQ_DEPTH];
  logic [LOG_IQ_DEPTH-1:0] head;
  logic [LOG_IQ_DEPTH-1:0] tail;
  logic [LOG_IQ_DEPTH:0]   count;
  logic                    enq;
  logic                    deq;
  logic                    flush;

  // Flush overrides both enqueue and dequeue. Full and valid come from
  // registered count only, so the fetch stall never depends on dispatch_ready.
  assign flush             = from_pipeline_take_resolved;
  assign iq_full           = (count == CNT_FULL);
  assign to_dispatch_valid = (count != '0);
  assign enq               = from_fetch_ivalid & ~iq_full & ~flush;
  assign deq               = to_dispatch_valid & dispatch_ready & ~flush;

  assign iq_count          = count;
  assign to_dispatch_instr = instr_mem[head];
  assign to_dispatch_PC    = pc_mem[head];
  assign to_dispatch_nPC   = npc_mem[head];

  // Pointers wrap by natural overflow of their LOG_IQ_DEPTH-bit width.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_ONE;
      if (deq) head <= head + PTR_ONE;
      case ({enq, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage clears only on reset; a flush just rewinds the pointers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
        npc_mem[i]   <= '0;
      end
    end else if (enq) begin
      instr_mem[tail] <= from_fetch_instr;
      pc_mem[tail]    <= from_fetch_PC;
      npc_mem[tail]   <= from_fetch_nPC;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_queue
//   Self-checking bench for instr_queue (IQ_DEPTH=4). A table of vectors
//   covers fill, full drop and drain. Hand sequences cover the multi-cycle
//   corners. A random phase is compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int LOG   = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          from_fetch_ivalid;
  logic [31:0]   from_fetch_instr;
  logic [13:0]   from_fetch_PC;
  logic [13:0]   from_fetch_nPC;
  logic          from_pipeline_take_resolved;
  logic          dispatch_ready;
  logic          to_dispatch_valid;
  logic [31:0]   to_dispatch_instr;
  logic [13:0]   to_dispatch_PC;
  logic [13:0]   to_dispatch_nPC;
  logic          iq_full;
  logic [LOG:0]  iq_count;

  instr_queue #(.IQ_DEPTH(DEPTH), .LOG_IQ_DEPTH(LOG)) dut (
    .CLK                         (CLK),
    .nRST                        (nRST),
    .from_fetch_ivalid           (from_fetch_ivalid),
    .from_fetch_instr            (from_fetch_instr),
    .from_fetch_PC               (from_fetch_PC),
    .from_fetch_nPC              (from_fetch_nPC),
    .from_pipeline_take_resolved (from_pipeline_take_resolved),
    .dispatch_ready              (dispatch_ready),
    .to_dispatch_valid           (to_dispatch_valid),
    .to_dispatch_instr           (to_dispatch_instr),
    .to_dispatch_PC              (to_dispatch_PC),
    .to_dispatch_nPC             (to_dispatch_nPC),
    .iq_full                     (iq_full),
    .iq_count                    (iq_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [13:0] pc;
    logic [13:0] npc;
  } entry_t;

  typedef struct {
    logic        ivalid;
    logic [13:0] pc;
    logic        ready;
    logic        flush;
    logic        exp_valid;
    int          exp_count;
    logic        exp_full;
    logic [13:0] exp_pc;
  } vec_t;

  entry_t model_q[$];
  vec_t   vecs[$];
  int     n_compared   = 0;
  int     n_mismatched = 0;
  int     n_protocol   = 0;

  function automatic logic [31:0] instrOf(input logic [13:0] pc);
    return 32'hA500_0000 | 32'(pc);
  endfunction

  function automatic vec_t mkv(input logic iv, input logic [13:0] pc, input logic rdy,
                               input logic fl, input logic ev, input int ec,
                               input logic ef, input logic [13:0] epc);
    vec_t v;
    v.ivalid = iv; v.pc = pc; v.ready = rdy; v.flush = fl;
    v.exp_valid = ev; v.exp_count = ec; v.exp_full = ef; v.exp_pc = epc;
    return v;
  endfunction

  // Drive the inputs for the coming edge and advance the reference model to
  // the state the queue must hold after that edge.
  task automatic applyStimulus(input logic iv, input logic [31:0] ins, input logic [13:0] pc,
                               input logic [13:0] npc, input logic fl, input logic rdy);
    entry_t e;
    bit     do_enq;
    bit     do_deq;
    from_fetch_ivalid           = iv;
    from_fetch_instr            = ins;
    from_fetch_PC               = pc;
    from_fetch_nPC              = npc;
    from_pipeline_take_resolved = fl;
    dispatch_ready              = rdy;
    e.instr = ins; e.pc = pc; e.npc = npc;
    if (fl) begin
      model_q.delete();
    end else begin
      do_enq = iv && (model_q.size() < DEPTH);
      do_deq = rdy && (model_q.size() > 0);
      if (iv && !do_enq) n_protocol++;
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " valid"}, 32'(to_dispatch_valid), 32'(model_q.size() != 0));
    checkOutput({tag, " count"}, 32'(iq_count), 32'(model_q.size()));
    checkOutput({tag, " full"}, 32'(iq_full), 32'(model_q.size() == DEPTH));
    if (model_q.size() != 0) begin
      checkOutput({tag, " instr"}, to_dispatch_instr, model_q[0].instr);
      checkOutput({tag, " pc"}, 32'(to_dispatch_PC), 32'(model_q[0].pc));
      checkOutput({tag, " npc"}, 32'(to_dispatch_nPC), 32'(model_q[0].npc));
    end
  endtask

  task automatic cycle(input logic iv, input logic [13:0] pc, input logic fl,
                       input logic rdy, input string tag);
    applyStimulus(iv, instrOf(pc), pc, pc + 14'd1, fl, rdy);
    step();
    checkModel(tag);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " valid"}, 32'(to_dispatch_valid), 32'd0);
    checkOutput({tag, " count"}, 32'(iq_count), 32'd0);
    checkOutput({tag, " full"}, 32'(iq_full), 32'd0);
    checkOutput({tag, " instr"}, to_dispatch_instr, 32'd0);
    checkOutput({tag, " pc"}, 32'(to_dispatch_PC), 32'd0);
    checkOutput({tag, " npc"}, 32'(to_dispatch_nPC), 32'd0);
  endtask

  initial begin
    nRST = 1'b0;
    applyStimulus(1'b0, 32'd0, 14'd0, 14'd0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    checkAllZero("in-reset");
    nRST = 1'b1;
    step();
    checkAllZero("post-reset");

    // Fill to full, attempt a drop while full, then drain in order.
    vecs.push_back(mkv(1, 14'h10, 0, 0, 1, 1, 0, 14'h10));
    vecs.push_back(mkv(1, 14'h11, 0, 0, 1, 2, 0, 14'h10));
    vecs.push_back(mkv(1, 14'h12, 0, 0, 1, 3, 0, 14'h10));
    vecs.push_back(mkv(1, 14'h13, 0, 0, 1, 4, 1, 14'h10));
    vecs.push_back(mkv(1, 14'h20, 0, 0, 1, 4, 1, 14'h10));
    vecs.push_back(mkv(0, 14'h00, 1, 0, 1, 3, 0, 14'h11));
    vecs.push_back(mkv(0, 14'h00, 1, 0, 1, 2, 0, 14'h12));
    vecs.push_back(mkv(0, 14'h00, 1, 0, 1, 1, 0, 14'h13));
    vecs.push_back(mkv(0, 14'h00, 1, 0, 0, 0, 0, 14'h00));
    vecs.push_back(mkv(0, 14'h00, 1, 0, 0, 0, 0, 14'h00));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ivalid, instrOf(vecs[i].pc), vecs[i].pc, vecs[i].pc + 14'd1,
                    vecs[i].flush, vecs[i].ready);
      step();
      checkOutput($sformatf("vec%0d valid", i), 32'(to_dispatch_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d count", i), 32'(iq_count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d full", i), 32'(iq_full), 32'(vecs[i].exp_full));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d pc", i), 32'(to_dispatch_PC), 32'(vecs[i].exp_pc));
        checkOutput($sformatf("vec%0d instr", i), to_dispatch_instr, instrOf(vecs[i].exp_pc));
      end
    end

    // Simultaneous enqueue/dequeue at count 2; pointers wrap past 3.
    cycle(1, 14'h30, 0, 0, "pre-simul");
    cycle(1, 14'h31, 0, 0, "pre-simul");
    for (int k = 0; k < 6; k++) begin
      cycle(1, 14'h50 + 14'(k), 0, 1, "simul");
      checkOutput("simul count", 32'(iq_count), 32'd2);
      checkOutput("simul head pc", 32'(to_dispatch_PC), (k == 0) ? 32'h31 : 32'h50 + 32'(k - 1));
    end

    // Flush at count 3 beats a concurrent enqueue and dequeue.
    cycle(1, 14'h3F, 0, 0, "pre-flush");
    checkOutput("pre-flush count", 32'(iq_count), 32'd3);
    cycle(1, 14'h3E, 1, 1, "flush");
    checkOutput("flush count", 32'(iq_count), 32'd0);
    checkOutput("flush valid", 32'(to_dispatch_valid), 32'd0);
    cycle(1, 14'h40, 0, 0, "post-flush");
    checkOutput("post-flush pc", 32'(to_dispatch_PC), 32'h40);

    // Flush while full, then flush while empty.
    for (int k = 0; k < 3; k++) cycle(1, 14'h41 + 14'(k), 0, 0, "refill");
    checkOutput("refill full", 32'(iq_full), 32'd1);
    cycle(0, 14'h0, 1, 0, "flush-full");
    checkOutput("flush-full full", 32'(iq_full), 32'd0);
    cycle(0, 14'h0, 1, 1, "flush-empty");

    // Empty boundary: no same-cycle bypass.
    applyStimulus(1'b1, 32'h8C22_0004, 14'h60, 14'h61, 1'b0, 1'b1);
    checkOutput("empty same-cycle valid", 32'(to_dispatch_valid), 32'd0);
    step();
    checkOutput("empty next valid", 32'(to_dispatch_valid), 32'd1);
    checkOutput("empty next instr", to_dispatch_instr, 32'h8C22_0004);

    // Asynchronous reset between edges at count 3.
    cycle(1, 14'h61, 0, 0, "pre-reset");
    cycle(1, 14'h62, 0, 0, "pre-reset");
    checkOutput("pre-reset count", 32'(iq_count), 32'd3);
    applyStimulus(1'b0, 32'd0, 14'd0, 14'd0, 1'b0, 1'b0);
    #3;
    nRST = 1'b0;
    #1;
    checkAllZero("async-reset");
    model_q.delete();
    @(posedge CLK);
    #3;
    nRST = 1'b1;
    step();
    checkAllZero("reset-release");
    cycle(1, 14'h70, 0, 0, "first-after-reset");
    checkOutput("first-after-reset pc", 32'(to_dispatch_PC), 32'h70);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(logic'($urandom_range(0, 9) < 7), $urandom, 14'($urandom), 14'($urandom),
                    logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 9) < 5));
      step();
      checkModel("rand");
    end

    $display("[TB] protocol errors (ivalid while iq_full, dropped): %0d", n_protocol);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4, meaning the number of instruction entries; legal values are powers of two, 2 or greater.
REQ-002 SHALL have parameter LOG_IQ_DEPTH, default 2, meaning log2(IQ_DEPTH).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port from_fetch_ivalid, input, 1 bit: fetch presents a valid instruction this cycle.
REQ-006 SHALL have port from_fetch_instr, input, 32 bits (word_t): the fetched instruction.
REQ-007 SHALL have port from_fetch_PC, input, 14 bits (pc_t): word-granular PC of the instruction.
REQ-008 SHALL have port from_fetch_nPC, input, 14 bits (pc_t): the next PC predicted by fetch.
REQ-009 SHALL have port from_pipeline_take_resolved, input, 1 bit: redirect/flush request.
REQ-010 SHALL have port dispatch_ready, input, 1 bit: downstream accepts the head entry this cycle.
REQ-011 SHALL have port to_dispatch_valid, output, 1 bit: the head entry is valid.
REQ-012 SHALL have ports to_dispatch_instr (32 bits), to_dispatch_PC (14 bits) and to_dispatch_nPC (14 bits), output: fields of the head entry.
REQ-013 SHALL have port iq_full, output, 1 bit: the queue holds IQ_DEPTH entries; drives the fetch stall.
REQ-014 SHALL have port iq_count, output, LOG_IQ_DEPTH+1 bits: current occupancy.

Function
REQ-015 SHALL store entries {instr, PC, nPC} in a circular buffer of IQ_DEPTH entries, indexed by a head pointer and a tail pointer, each LOG_IQ_DEPTH bits.
REQ-016 SHALL wrap both pointers modulo IQ_DEPTH by natural overflow (for IQ_DEPTH=4, index 3 + 1 = 0).
REQ-017 SHALL enqueue when from_fetch_ivalid & ~iq_full & ~from_pipeline_take_resolved: write the entry at tail, then tail += 1.
REQ-018 SHALL dequeue when to_dispatch_valid & dispatch_ready & ~from_pipeline_take_resolved: head += 1.
REQ-019 SHALL, on a simultaneous enqueue and dequeue, leave count unchanged while both pointers advance.
REQ-020 SHALL otherwise update count by +1 on enqueue alone and by -1 on dequeue alone.
REQ-021 SHALL never let count exceed IQ_DEPTH or go below 0.
REQ-022 SHALL drop from_fetch_ivalid received while iq_full, with no state change; the bench flags this as a protocol error.
REQ-023 SHALL drive to_dispatch_valid = (count != 0), and to_dispatch_* as a combinational read of the entry at head.
REQ-024 SHALL have a minimum latency of 1 cycle from enqueue to visibility at to_dispatch_*; there is no same-cycle bypass.
REQ-025 SHALL drive iq_full = (count == IQ_DEPTH) combinationally from registered state, so it does not depend on dispatch_ready.
REQ-026 SHALL, on flush (from_pipeline_take_resolved=1), set head=0, tail=0 and count=0 at the next edge, taking priority over enqueue and dequeue that cycle.
REQ-027 SHALL leave stored entry contents unchanged on flush.
REQ-028 SHALL keep flush effective even when the queue is empty or full.
REQ-029 SHALL hold all state when there is no enqueue, dequeue or flush.
REQ-030 SHALL, with count=0 and dispatch_ready=1, perform no dequeue and leave head unchanged.

Reset
REQ-031 SHALL, on nRST low, immediately and asynchronously set head=0, tail=0, count=0 and all entry fields to 0.
REQ-032 SHALL drive these outputs during and after reset: to_dispatch_valid=0, iq_full=0, iq_count=0, to_dispatch_instr=0, to_dispatch_PC=0, to_dispatch_nPC=0.
REQ-033 SHALL, on reset asserted mid-operation, discard all in-flight entries; the first enqueue after release writes entry 0.

Verification
REQ-034 SHALL cover fill and drain: IQ_DEPTH=4, enqueue PC=0x10,0x11,0x12,0x13 with dispatch_ready=0 -> iq_full=1 and iq_count=4 after 4th edge; then dispatch_ready=1 -> heads 0x10..0x13 in order, then valid=0.
REQ-035 SHALL cover full drop: queue full, ivalid=1 with PC=0x20 -> count stays 4 and PC 0x20 never appears at to_dispatch_PC.
REQ-036 SHALL cover simultaneous enqueue/dequeue: count=2, ivalid=1 and dispatch_ready=1 for 6 cycles -> count stays 2, both pointers wrap past 3 to 0, output order preserved.
REQ-037 SHALL cover flush: count=3, take_resolved=1 with ivalid=1 and dispatch_ready=1 -> next cycle count=0 and valid=0; a following enqueue of PC=0x40 appears at head one cycle later.
REQ-038 SHALL cover async reset: assert nRST low between edges with count=3 -> valid=0, iq_count=0 and iq_full=0 before the next edge.
REQ-039 SHALL cover the empty boundary: count=0, dispatch_ready=1, ivalid=1 with instr=0x8C220004 -> valid=0 this cycle; next cycle valid=1 and to_dispatch_instr=0x8C220004.
